// File: rtl/vga_pkg.sv
// Shared VGA constants and the line-fetch FSM state type.
package vga_pkg;

  localparam int unsigned H_VISIBLE  = 640;
  localparam int unsigned H_TOTAL    = 800;
  localparam int unsigned V_VISIBLE  = 480;
  localparam int unsigned V_TOTAL    = 525;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned LINE_WORDS = H_VISIBLE / DATA_W;
  localparam int unsigned LINE_W     = 10;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DRAIN = 2'd2,
    FS_DONE  = 2'd3
  } fetch_state_e;

  // True while a line fetch still owns (or is draining) the SRAM read path.
  function automatic logic is_fetching(input fetch_state_e s);
    return (s == FS_FETCH) || (s == FS_DRAIN);
  endfunction

endpackage

// File: rtl/vga_line_buf.sv
// Double-buffered line store: one write port into the fill bank, one
// registered read port from the display bank selected by disp_bank.
module vga_line_buf #(
  parameter  int unsigned DATA_W     = 16,
  parameter  int unsigned LINE_WORDS = 40,
  localparam int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_bank,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2][LINE_WORDS];
  logic [DATA_W-1:0] rd_data_q;

  // Storage is never cleared; only the fill bank (opposite of display) is written.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_idx) < LINE_WORDS)) begin
      mem_q[~disp_bank][wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (32'(rd_idx) < LINE_WORDS) begin
      rd_data_q <= mem_q[disp_bank][rd_idx];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_line_fetch_arb.sv
// Line prefetch into a double buffer plus SRAM arbitration against a pixel writer.
// Optional VGA_ARB_WR_FAIR_EN: give a pending writer every 4th fetch slot.
module vga_line_fetch_arb
  import vga_pkg::*;
#(
  parameter  int unsigned ADDR_W     = vga_pkg::ADDR_W,
  parameter  int unsigned DATA_W     = vga_pkg::DATA_W,
  parameter  int unsigned LINE_WORDS = vga_pkg::LINE_WORDS,
  parameter  int unsigned V_VISIBLE  = vga_pkg::V_VISIBLE,
  localparam int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic [LINE_W-1:0] fetch_line,
  input  logic              line_swap,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              fetch_busy,
  output logic              fetch_late
);

  fetch_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              issue_q, issue_d;
  logic [IDX_W-1:0]  issue_idx_q, issue_idx_d;
  logic              cap_vld_q, cap_vld_d;
  logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;
  logic              sel_q, sel_d;
  logic              late_q, late_d;
  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic              ack_q, ack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic start_go, restart, fair_slot, rd_go, wr_go;

`ifdef VGA_ARB_WR_FAIR_EN
  logic [1:0] slot_q, slot_d, slot_eff;
`endif

  // Next-state, arbitration and registered bus values for the coming cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    issue_d     = 1'b0;
    issue_idx_d = issue_idx_q;
    sel_d       = sel_q;
    late_d      = late_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    ack_d       = 1'b0;
    fair_slot   = 1'b0;
    rd_go       = 1'b0;
    wr_go       = 1'b0;

    start_go = fetch_start && (32'(fetch_line) < V_VISIBLE);
    restart  = start_go && ((state_q == FS_IDLE) || line_swap);

    if (line_swap) begin
      sel_d = ~sel_q;
      if (is_fetching(state_q)) late_d = 1'b1;
    end

    if (line_swap && (state_q != FS_IDLE)) begin
      state_d = FS_IDLE;
    end else begin
      unique case (state_q)
        FS_IDLE:  state_d = FS_IDLE;
        FS_FETCH: if (issue_q && (issue_idx_q == IDX_W'(LINE_WORDS - 1))) state_d = FS_DRAIN;
        FS_DRAIN: state_d = FS_DONE;
        FS_DONE:  state_d = FS_DONE;
      endcase
    end

    // A swap is applied first, so a same-cycle start fetches into the new fill bank.
    if (restart) begin
      state_d = FS_FETCH;
      idx_d   = '0;
      base_d  = ADDR_W'(32'(fetch_line) * LINE_WORDS);
    end

`ifdef VGA_ARB_WR_FAIR_EN
    slot_eff  = restart ? 2'd0 : slot_q;
    fair_slot = (state_d == FS_FETCH) && (slot_eff == 2'd3) && wr_req && !ack_q;
    slot_d    = slot_eff;
`endif

    rd_go = (state_d == FS_FETCH) && !fair_slot;
    wr_go = wr_req && !ack_q && ((state_d != FS_FETCH) || fair_slot);

    if (rd_go) begin
      issue_d     = 1'b1;
      issue_idx_d = idx_d;
      addr_d      = base_d + ADDR_W'(idx_d);
      idx_d       = idx_d + IDX_W'(1);
`ifdef VGA_ARB_WR_FAIR_EN
      if (slot_eff != 2'd3) slot_d = slot_eff + 2'd1;
`endif
    end else if (wr_go) begin
      addr_d  = wr_addr;
      wdata_d = wr_data;
      we_d    = 1'b1;
      ack_d   = 1'b1;
`ifdef VGA_ARB_WR_FAIR_EN
      slot_d  = 2'd0;
`endif
    end

    // Data returning from an aborted fetch is dropped.
    cap_vld_d = issue_q && !line_swap;
    cap_idx_d = issue_idx_q;
    busy_d    = is_fetching(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FS_IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      issue_q     <= 1'b0;
      issue_idx_q <= '0;
      cap_vld_q   <= 1'b0;
      cap_idx_q   <= '0;
      sel_q       <= 1'b0;
      late_q      <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      ack_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      issue_q     <= issue_d;
      issue_idx_q <= issue_idx_d;
      cap_vld_q   <= cap_vld_d;
      cap_idx_q   <= cap_idx_d;
      sel_q       <= sel_d;
      late_q      <= late_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      ack_q       <= ack_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

`ifdef VGA_ARB_WR_FAIR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot_q <= 2'd0;
    else       slot_q <= slot_d;
  end
`endif

  vga_line_buf #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk       (clk),
    .reset     (reset),
    .disp_bank (sel_q),
    .wr_en     (cap_vld_q && !line_swap),
    .wr_idx    (cap_idx_q),
    .wr_data   (sram_rdata),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data)
  );

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_we    = we_q;
  assign wr_ack     = ack_q;
  assign fetch_busy = busy_q;
  assign fetch_late = late_q;

endmodule
